br_flow_checks_monitor: RTL and testbench
=========================================

BR_FLOW_CHECKS_MONITOR -- requirements
Module: br_flow_checks_monitor

Interface
REQ-001 SHALL have parameter NumFlows, default 1: number of ready-valid flows monitored; at least 1.
REQ-002 SHALL have parameter Width, default 1: data width per flow; at least 1.
REQ-003 SHALL have parameter EnableCheckValidStability, default 1: 1 flags valid dropped under backpressure.
REQ-004 SHALL have parameter EnableCheckDataStability, default 1: 1 flags data changed under backpressure; legal only with EnableCheckValidStability=1, enforced by static assertion.
REQ-005 SHALL have parameter StallTimeout, default 0: 0 disables timeout; otherwise the consecutive-backpressure limit, 1..2^StallWidth-1, enforced by static assertion.
REQ-006 SHALL have parameter StallWidth, default 8: width of the stall counters; at least 1.
REQ-007 SHALL have parameter CountWidth, default 16: width of the transfer counters; at least 1.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-009 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port valid, input, [NumFlows]: per-flow valid.
REQ-011 SHALL have port ready, input, [NumFlows]: per-flow ready.
REQ-012 SHALL have port data, input, [NumFlows][Width]: per-flow data.
REQ-013 SHALL have port clear, input, 1 bit: single-cycle request to clear sticky errors, counters and max-stall.
REQ-014 SHALL have port err_valid_drop, output, [NumFlows]: sticky flag, valid deasserted while a transfer was pending.
REQ-015 SHALL have port err_data_change, output, [NumFlows]: sticky flag, data changed while a transfer was pending.
REQ-016 SHALL have port err_stall_timeout, output, [NumFlows]: sticky flag, backpressure held for StallTimeout consecutive cycles.
REQ-017 SHALL have port any_error, output, 1 bit: OR of all error flags.
REQ-018 SHALL have port xfer_count, output, [NumFlows][CountWidth]: completed transfers per flow.
REQ-019 SHALL have port max_stall, output, [NumFlows][StallWidth]: longest backpressure run seen per flow.

Function
REQ-020 SHALL keep a two-state FSM per flow, IDLE or PENDING, where PENDING means a valid&!ready cycle occurred and that cycle's data is held in a capture register.
- IDLE: valid&!ready -> PENDING, capture data.
- PENDING: valid&ready -> IDLE; valid&!ready -> stay in PENDING, keep the original capture; !valid -> IDLE.
REQ-021 SHALL, when in PENDING with valid=0 and EnableCheckValidStability=1, set err_valid_drop[i] on the next cycle.
REQ-022 SHALL, when in PENDING with valid=1 and data != capture and EnableCheckDataStability=1, set err_data_change[i] on the next cycle; this applies whether ready is 0 or 1.
REQ-023 SHALL keep a stall counter per flow:
- valid&!ready: increments, saturating at 2^StallWidth-1.
- any other cycle: goes to 0.
REQ-024 SHALL set err_stall_timeout[i] on the cycle the stall counter value becomes >= StallTimeout, when StallTimeout != 0; this occurs after StallTimeout consecutive backpressured cycles.
REQ-025 SHALL update max_stall[i] to the larger of max_stall[i] and the next stall counter value on every cycle.
REQ-026 SHALL increment xfer_count[i] by 1 on each valid&ready cycle, wrapping modulo 2^CountWidth with no error on wrap.
REQ-027 SHALL latch all error flags once set until clear or rst.
REQ-028 SHALL, when clear=1, on the next cycle zero the error flags, xfer_count and max_stall, but not the FSM state, capture register or stall counter.
REQ-029 SHALL, when clear and an error, transfer or stall event occur in the same cycle, give the event priority: the flag is 1, xfer_count is 1 and max_stall equals the new stall value.
REQ-030 SHALL register all outputs, with any_error combinational from the registered flags.
REQ-031 SHALL keep flows fully independent, with no cross-flow interaction.
REQ-032 SHALL NOT drive valid, ready or data; the block is a passive observer.
REQ-033 SHALL treat X on data when valid=1 as a simulation-only integrity assertion, not a flag.

Reset
REQ-034 SHALL, while rst=1, hold the FSM at IDLE and drive all error flags, any_error, xfer_count, max_stall and the stall counters to 0.
REQ-035 SHALL abandon any pending transfer on reset mid-operation, with no error for the abandoned transfer; checking restarts on the first cycle after rst=0.
REQ-036 SHALL NOT reset the capture register; its contents are don't-care while in IDLE.

Verification
REQ-037 SHALL cover clean backpressure with NumFlows=2, Width=8:
- Stimulus: flow 0 valid with data=0xA5, ready=0 for 3 cycles, then ready=1.
- Response: no errors; xfer_count[0]=1; max_stall[0]=3; flow 1 all zero.
REQ-038 SHALL cover valid drop:
- Stimulus: valid=1, ready=0 for 1 cycle, then valid=0.
- Response: err_valid_drop[0]=1 and any_error=1 one cycle later, held indefinitely.
REQ-039 SHALL cover data change:
- Stimulus: data=0x11 with valid=1, ready=0; next cycle data=0x22 with ready=1.
- Response: err_data_change[0]=1 next cycle; xfer_count[0]=1.
REQ-040 SHALL cover stall timeout:
- Stimulus: StallTimeout=4, valid=1, ready=0 for 4 cycles.
- Response: err_stall_timeout set at the 4th cycle edge, not earlier.
- With StallWidth=2, a 10-cycle stall gives max_stall=3 (saturated).
REQ-041 SHALL cover clear and reset:
- Stimulus: clear is pulsed in the same cycle as a new valid drop.
- Response: flag remains 1; a later clear-only pulse gives 0.
- Stimulus: rst mid-stall.
- Response: all outputs 0, no error on release.
REQ-042 SHALL cover counter wrap:
- Stimulus: CountWidth=2, 5 transfers.
- Response: xfer_count=1, no error.

Source files
------------

// File: rtl/br_flow_checks_monitor.sv
// Purpose: passive protocol monitor for NumFlows ready-valid flows, with sticky stability/stall errors and per-flow statistics.
// Latency: each event shows on the registered outputs one cycle after the cycle it occurs in; any_error is combinational from the flags.
// Backpressure: never drives valid, ready or data. It only watches valid&!ready runs and does not influence them.
//
// Ports:
//   clk, rst           - single clock; synchronous active-high reset
//   valid/ready/data   - observed per-flow handshake and payload
//   clear              - one-cycle pulse that zeroes the error flags, xfer_count and max_stall
//   err_valid_drop     - sticky: valid fell while a transfer was pending
//   err_data_change    - sticky: data moved while a transfer was pending
//   err_stall_timeout  - sticky: backpressure lasted StallTimeout consecutive cycles
//   any_error          - OR of every error flag
//   xfer_count         - completed transfers per flow (wraps)
//   max_stall          - longest backpressure run per flow (saturating)
module br_flow_checks_monitor #(
    parameter int NumFlows                  = 1,
    parameter int Width                     = 1,
    parameter int EnableCheckValidStability = 1,
    parameter int EnableCheckDataStability  = 1,
    parameter int StallTimeout              = 0,
    parameter int StallWidth                = 8,
    parameter int CountWidth                = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NumFlows-1:0]                  valid,
    input  logic [NumFlows-1:0]                  ready,
    input  logic [NumFlows-1:0][Width-1:0]       data,
    input  logic                                 clear,
    output logic [NumFlows-1:0]                  err_valid_drop,
    output logic [NumFlows-1:0]                  err_data_change,
    output logic [NumFlows-1:0]                  err_stall_timeout,
    output logic                                 any_error,
    output logic [NumFlows-1:0][CountWidth-1:0]  xfer_count,
    output logic [NumFlows-1:0][StallWidth-1:0]  max_stall
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (NumFlows < 1) begin : g_bad_num_flows
        $error("br_flow_checks_monitor: NumFlows must be at least 1");
    end
    if (Width < 1) begin : g_bad_width
        $error("br_flow_checks_monitor: Width must be at least 1");
    end
    if (StallWidth < 1) begin : g_bad_stall_width
        $error("br_flow_checks_monitor: StallWidth must be at least 1");
    end
    if (CountWidth < 1) begin : g_bad_count_width
        $error("br_flow_checks_monitor: CountWidth must be at least 1");
    end
    // Data stability is only meaningful while valid is held, so it needs the valid check.
    if ((EnableCheckDataStability != 0) && (EnableCheckValidStability == 0)) begin : g_bad_data_check
        $error("br_flow_checks_monitor: EnableCheckDataStability requires EnableCheckValidStability");
    end
    if ((StallTimeout < 0) ||
        ((StallWidth < 31) && (StallTimeout > (2 ** StallWidth) - 1))) begin : g_bad_timeout
        $error("br_flow_checks_monitor: StallTimeout must be 0 or 1..2^StallWidth-1");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Per-flow checker; flows share nothing but clk/rst/clear.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NumFlows; i++) begin : g_flow
        state_t                state_q;
        state_t                state_d;
        logic [Width-1:0]      capture_q;
        logic [StallWidth-1:0] stall_q;
        logic [StallWidth-1:0] stall_d;
        logic [StallWidth-1:0] max_q;
        logic [StallWidth-1:0] max_d;
        logic [CountWidth-1:0] count_q;
        logic [CountWidth-1:0] count_d;
        logic [CountWidth-1:0] count_base;
        logic                  vdrop_q;
        logic                  vdrop_d;
        logic                  dchg_q;
        logic                  dchg_d;
        logic                  tout_q;
        logic                  tout_d;
        logic                  stall_cyc;
        logic                  xfer_cyc;
        logic                  drop_evt;
        logic                  chg_evt;
        logic                  tout_evt;

        always_comb begin
            state_d    = state_q;
            stall_cyc  = valid[i] & ~ready[i];
            xfer_cyc   = valid[i] & ready[i];
            drop_evt   = 1'b0;
            chg_evt    = 1'b0;
            stall_d    = '0;
            max_d      = max_q;
            count_base = count_q;
            count_d    = count_q;
            vdrop_d    = vdrop_q;
            dchg_d     = dchg_q;
            tout_d     = tout_q;

            case (state_q)
                IDLE: begin
                    if (stall_cyc) begin
                        state_d = PENDING;
                    end
                end
                PENDING: begin
                    // Stay only while still backpressured; transfer or drop both end the attempt.
                    if (!valid[i] || ready[i]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if ((EnableCheckValidStability != 0) && (state_q == PENDING) && !valid[i]) begin
                drop_evt = 1'b1;
            end
            // Compared against the first backpressured beat, including on the accepting cycle.
            if ((EnableCheckDataStability != 0) && (state_q == PENDING) && valid[i] &&
                (data[i] != capture_q)) begin
                chg_evt = 1'b1;
            end

            if (stall_cyc) begin
                stall_d = (stall_q == '1) ? stall_q : stall_q + StallWidth'(1);
            end

            // Events win over a coincident clear: clear drops history, the event re-asserts.
            if (clear) begin
                max_d      = stall_d;
                count_base = '0;
            end else if (stall_d > max_q) begin
                max_d = stall_d;
            end
            count_d = xfer_cyc ? count_base + CountWidth'(1) : count_base;

            vdrop_d = (vdrop_q & ~clear) | drop_evt;
            dchg_d  = (dchg_q  & ~clear) | chg_evt;
            tout_d  = (tout_q  & ~clear) | tout_evt;
        end

        // Flag on the same edge the counter reaches the limit.
        if (StallTimeout != 0) begin : g_tout
            localparam logic [StallWidth-1:0] StallLimit = StallWidth'(StallTimeout);
            assign tout_evt = (stall_d >= StallLimit);
        end else begin : g_no_tout
            assign tout_evt = 1'b0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                stall_q <= '0;
                max_q   <= '0;
                count_q <= '0;
                vdrop_q <= 1'b0;
                dchg_q  <= 1'b0;
                tout_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                stall_q <= stall_d;
                max_q   <= max_d;
                count_q <= count_d;
                vdrop_q <= vdrop_d;
                dchg_q  <= dchg_d;
                tout_q  <= tout_d;
            end
        end

        // Capture is deliberately unreset: it is only read while PENDING,
        // and PENDING is only entered through a capture.
        always_ff @(posedge clk) begin
            if ((state_q == IDLE) && stall_cyc) begin
                capture_q <= data[i];
            end
        end

        data_known_a : assert property (@(posedge clk) disable iff (rst)
            valid[i] |-> !$isunknown(data[i]));

        assign err_valid_drop[i]    = vdrop_q;
        assign err_data_change[i]   = dchg_q;
        assign err_stall_timeout[i] = tout_q;
        assign xfer_count[i]        = count_q;
        assign max_stall[i]         = max_q;
    end

    assign any_error = (|err_valid_drop) | (|err_data_change) | (|err_stall_timeout);

endmodule

// File: tb/tb_br_flow_checks_monitor.sv
module tb_br_flow_checks_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: two 8-bit flows, timeout of 4
    logic [1:0]       va, ra;
    logic [1:0][7:0]  da;
    logic             clear_a;
    logic [1:0]       vdrop_a, dchg_a, tout_a;
    logic             any_a;
    logic [1:0][15:0] xfer_a;
    logic [1:0][7:0]  max_a;

    // Instance B: one flow, narrow counters, timeout disabled
    logic [0:0]       vb, rb;
    logic [0:0][7:0]  db;
    logic             clear_b;
    logic [0:0]       vdrop_b, dchg_b, tout_b;
    logic             any_b;
    logic [0:0][1:0]  xfer_b;
    logic [0:0][1:0]  max_b;

    br_flow_checks_monitor #(
        .NumFlows(2), .Width(8), .EnableCheckValidStability(1), .EnableCheckDataStability(1),
        .StallTimeout(4), .StallWidth(8), .CountWidth(16)
    ) dut_a (
        .clk(clk), .rst(rst), .valid(va), .ready(ra), .data(da), .clear(clear_a),
        .err_valid_drop(vdrop_a), .err_data_change(dchg_a), .err_stall_timeout(tout_a),
        .any_error(any_a), .xfer_count(xfer_a), .max_stall(max_a)
    );

    br_flow_checks_monitor #(
        .NumFlows(1), .Width(8), .EnableCheckValidStability(1), .EnableCheckDataStability(1),
        .StallTimeout(0), .StallWidth(2), .CountWidth(2)
    ) dut_b (
        .clk(clk), .rst(rst), .valid(vb), .ready(rb), .data(db), .clear(clear_b),
        .err_valid_drop(vdrop_b), .err_data_change(dchg_b), .err_stall_timeout(tout_b),
        .any_error(any_b), .xfer_count(xfer_b), .max_stall(max_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; clear_a = 1'b0; clear_b = 1'b0;
        va = '0; ra = '0; da = '0;
        vb = '0; rb = '0; db = '0;
        #1;
        tick(2);
        check_eq("rst_any_a",   32'(any_a), 32'd0);
        check_eq("rst_flags_a", 32'({vdrop_a, dchg_a, tout_a}), 32'd0);
        check_eq("rst_xfer_a",  32'(xfer_a), 32'd0);
        check_eq("rst_max_a",   32'(max_a), 32'd0);
        check_eq("rst_b",       32'({any_b, xfer_b, max_b}), 32'd0);
        rst = 1'b0;

        // Clean backpressure: 3 stalled cycles then accept
        va[0] = 1'b1; da[0] = 8'hA5; ra[0] = 1'b0;
        tick(3);
        check_eq("bp_no_timeout_at3", 32'(tout_a[0]), 32'd0);
        check_eq("bp_max_at3",        32'(max_a[0]), 32'd3);
        ra[0] = 1'b1;
        tick(1);
        va[0] = 1'b0; ra[0] = 1'b0;
        tick(1);
        check_eq("bp_any",    32'(any_a), 32'd0);
        check_eq("bp_xfer0",  32'(xfer_a[0]), 32'd1);
        check_eq("bp_max0",   32'(max_a[0]), 32'd3);
        check_eq("bp_flow1",  32'({vdrop_a[1], dchg_a[1], tout_a[1], xfer_a[1], max_a[1]}), 32'd0);

        clear_a = 1'b1; tick(1); clear_a = 1'b0;
        check_eq("clr_xfer0", 32'(xfer_a[0]), 32'd0);
        check_eq("clr_max0",  32'(max_a[0]), 32'd0);

        // Data change on the accepting cycle
        va[0] = 1'b1; ra[0] = 1'b0; da[0] = 8'h11;
        tick(1);
        da[0] = 8'h22; ra[0] = 1'b1;
        tick(1);
        check_eq("dchg_flag", 32'(dchg_a[0]), 32'd1);
        check_eq("dchg_xfer", 32'(xfer_a[0]), 32'd1);
        check_eq("dchg_any",  32'(any_a), 32'd1);
        va[0] = 1'b0; ra[0] = 1'b0;
        tick(1);
        check_eq("dchg_no_drop", 32'(vdrop_a[0]), 32'd0);
        clear_a = 1'b1; tick(1); clear_a = 1'b0;
        check_eq("dchg_cleared", 32'(dchg_a[0]), 32'd0);
        check_eq("dchg_any_clr", 32'(any_a), 32'd0);

        // Valid drop coinciding with clear: event wins
        va[0] = 1'b1; ra[0] = 1'b0; da[0] = 8'h5A;
        tick(1);
        va[0] = 1'b0; clear_a = 1'b1;
        tick(1);
        clear_a = 1'b0;
        check_eq("drop_vs_clear", 32'(vdrop_a[0]), 32'd1);
        check_eq("drop_any",      32'(any_a), 32'd1);
        check_eq("drop_clr_max",  32'(max_a[0]), 32'd0);
        tick(3);
        check_eq("drop_sticky",   32'(vdrop_a[0]), 32'd1);
        clear_a = 1'b1; tick(1); clear_a = 1'b0;
        check_eq("drop_cleared",  32'(vdrop_a[0]), 32'd0);
        check_eq("drop_any_clr",  32'(any_a), 32'd0);

        // Clear coinciding with a transfer, then with a stall
        va[0] = 1'b1; ra[0] = 1'b1; da[0] = 8'h01; clear_a = 1'b1;
        tick(1);
        check_eq("clr_vs_xfer", 32'(xfer_a[0]), 32'd1);
        ra[0] = 1'b0;
        tick(1);
        check_eq("clr_vs_stall_max",  32'(max_a[0]), 32'd1);
        check_eq("clr_vs_stall_xfer", 32'(xfer_a[0]), 32'd0);
        clear_a = 1'b0; ra[0] = 1'b1;
        tick(1);
        va[0] = 1'b0; ra[0] = 1'b0;
        tick(1);
        check_eq("clr_seq_any", 32'(any_a), 32'd0);

        // Stall timeout at the 4th stalled edge, then reset mid-stall
        clear_a = 1'b1; tick(1); clear_a = 1'b0;
        va[0] = 1'b1; ra[0] = 1'b0; da[0] = 8'h33;
        tick(3);
        check_eq("tout_not_at3", 32'(tout_a[0]), 32'd0);
        tick(1);
        check_eq("tout_at4",     32'(tout_a[0]), 32'd1);
        check_eq("tout_max4",    32'(max_a[0]), 32'd4);
        tick(2);
        rst = 1'b1;
        tick(1);
        check_eq("rst_mid_flags", 32'({vdrop_a, dchg_a, tout_a}), 32'd0);
        check_eq("rst_mid_any",   32'(any_a), 32'd0);
        check_eq("rst_mid_stats", 32'({xfer_a, max_a}), 32'd0);
        rst = 1'b0; va[0] = 1'b0;
        tick(2);
        check_eq("rst_release_any", 32'(any_a), 32'd0);

        // Instance B: saturating stall, disabled timeout, counter wrap
        vb[0] = 1'b1; rb[0] = 1'b0; db[0] = 8'h40;
        tick(10);
        check_eq("b_max_sat",    32'(max_b[0]), 32'd3);
        check_eq("b_no_timeout", 32'(tout_b[0]), 32'd0);
        rb[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            db[0] = db[0] + 8'd1;
        end
        check_eq("b_wrap_at4", 32'(xfer_b[0]), 32'd0);
        tick(1);
        vb[0] = 1'b0; rb[0] = 1'b0;
        check_eq("b_wrap_at5", 32'(xfer_b[0]), 32'd1);
        check_eq("b_any",      32'(any_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
